// File: rtl/bus_reg_pkg.sv
// Shared definitions for the req/gnt register slave: register map, reset values, FSM states.
package bus_reg_pkg;

  localparam logic [7:0] OFF_ID     = 8'h00;
  localparam logic [7:0] OFF_CTRL   = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_ERR    = 8'h10;

  localparam logic [31:0] CTRL_RST  = 32'h0000_0000;
  localparam logic [31:0] DATA_RST  = 32'h0000_0000;
  localparam logic        ERR_RST   = 1'b0;
  localparam logic [15:0] ACC_RST   = 16'h0000;
  localparam logic [31:0] CTRL_MASK = 32'h0000_00FF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } bus_slv_state_e;

endpackage

// File: rtl/bus_reg_file.sv
// Register file behind the slave: ID, CTRL, DATA, STATUS (access counter) and sticky ERR.
module bus_reg_file
  import bus_reg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'hA5E4_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  off_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic        commit_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] acc_q, acc_d;
  logic        mapped;
  logic [31:0] reg_val;

  always_comb begin
    mapped  = 1'b1;
    reg_val = '0;
    case (off_i)
      OFF_ID:     reg_val = ID_VALUE;
      OFF_CTRL:   reg_val = ctrl_q;
      OFF_DATA:   reg_val = data_q;
      OFF_STATUS: reg_val = {16'h0000, acc_q};
      OFF_ERR:    reg_val = {31'h0, err_q};
      default:    mapped = 1'b0;
    endcase
  end

  // Neither enable set means the window check failed upstream.
  assign err_o   = ~(we_i | re_i) | ~mapped;
  assign rdata_o = (re_i & mapped) ? reg_val : '0;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    err_d  = err_q;
    acc_d  = acc_q;
    if (commit_i) begin
      if (we_i && mapped) begin
        case (off_i)
          OFF_CTRL: ctrl_d = wdata_i & CTRL_MASK;
          OFF_DATA: data_d = wdata_i;
          OFF_ERR:  if (wdata_i[0]) err_d = 1'b0;
          default:  ;
        endcase
      end
      // Set wins over a simultaneous W1C clear.
      if (err_o) err_d = 1'b1;
      if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_RST;
      data_q <= DATA_RST;
      err_q  <= ERR_RST;
      acc_q  <= ACC_RST;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      err_q  <= err_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/bus_reg_slave.sv
// req/gnt responder: captures a request, inserts wait states, then issues a registered one-cycle
// gnt with read data; the register file commits on the edge that ends the gnt cycle.
module bus_reg_slave
  import bus_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5E4_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        gnt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rw
);

  localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  bus_slv_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           hit_q, hit_d;
  logic [7:0]     off_q, off_d;
  logic           rw_q, rw_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           gnt_q, gnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    rf_rdata;
  logic           rf_err;
  logic           unused_addr;

  assign unused_addr = ^addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    off_d   = off_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    gnt_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          hit_d   = (addr[31:8] == BASE_ADDR[31:8]);
          off_d   = {addr[7:2], 2'b00};
          rw_d    = rw;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = GRANT;
          end else begin
            cnt_d   = WaitLoad;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = GRANT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      GRANT: begin
        gnt_d   = 1'b1;
        rdata_d = rf_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      off_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      off_q   <= off_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt   = gnt_q;
  assign rdata = rdata_q;

  bus_reg_file #(
    .ID_VALUE (ID_VALUE)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .off_i    (off_q),
    .we_i     (rw_q & hit_q),
    .re_i     (~rw_q & hit_q),
    .commit_i (gnt_q),
    .wdata_i  (wdata_q),
    .rdata_o  (rf_rdata),
    .err_o    (rf_err)
  );

  logic unused_rf_err;
  assign unused_rf_err = rf_err;

endmodule

// File: doc/bus_reg_slave.md
Name: bus_reg_slave

Overview:
- Responder end of the req/gnt bus used by the RAL example. Connects to the dut side of bus_if.
- Decodes a 32-bit address window and services reads and writes to a small memory-mapped register file.
- Inserts a programmable number of wait states before granting.
- Serves as the DUT that the RAL model and predictor are checked against.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base. A hit requires addr[31:8] == BASE_ADDR[31:8].
- WAIT_CYCLES, 0, wait states between accepting req and asserting gnt. Legal range 0..15.
- ID_VALUE, 32'hA5E4_0001, constant returned by the ID register.

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  initiator request. Held high until gnt is seen.
- gnt  output  1  one-cycle grant. Completes the transfer.
- addr  input  32  byte address. Valid while req is high; addr[1:0] is ignored.
- wdata  input  32  write data. Valid while req && rw.
- rdata  output  32  read data. Valid only in the gnt cycle of a read; 0 at all other times.
- rw  input  1  0 = read, 1 = write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; gnt=0, rdata=0.
  - All registers take their reset values.
  - Any in-flight transfer is dropped with no register side effect.
  - Deassertion is synchronous to clk.
- FSM states: IDLE, WAIT, GRANT.
  - IDLE: when req=1 is sampled, capture addr, rw and wdata.
    - If WAIT_CYCLES==0, go to GRANT.
    - Otherwise load wait_cnt=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement wait_cnt. When wait_cnt==0, go to GRANT. Changes on req during WAIT are ignored; the captured values are used.
  - GRANT: gnt=1 for exactly one cycle, then go to IDLE.
- Latency: req first sampled high at edge N gives gnt high in the cycle after edge N+1+WAIT_CYCLES.
- Back-to-back: IDLE may accept a new req on the edge immediately after GRANT. Minimum spacing between gnt pulses is WAIT_CYCLES+2 cycles.
- Writes commit on the edge that ends the GRANT cycle.
- Reads: rdata is driven from registered decode during GRANT. A read reflects every write whose GRANT ended earlier.
- Register map (word offsets from BASE_ADDR):
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 CTRL: RW, bits[7:0] only. Upper bits read 0 and writes to them are ignored. Reset 0.
  - 0x08 DATA: RW, full 32 bits. Reset 0.
  - 0x0C STATUS: RO, {16'h0, acc_cnt[15:0]}. acc_cnt increments on every completed gnt, including errors, and saturates at 16'hFFFF. Reset 0.
  - 0x10 ERR: bit0 is sticky error, W1C (writing 1 to bit0 clears it). Other bits read 0. Reset 0.
- Errors:
  - Triggers: an address outside the window, or an unmapped offset (0x14..0xFC).
  - Still granted: reads return 0; writes are dropped.
  - ERR[0] is set at the end of the GRANT cycle.
  - Writes to RO registers are silently ignored and do not set ERR.
- Same-cycle conflict: a W1C write to ERR coincides with a new error only when the ERR write itself is the erroring access, which cannot occur. Rule: set has priority over clear.
- acc_cnt saturation: at 0xFFFF, a further gnt holds 0xFFFF.

Decomposition:
- Package bus_reg_pkg holds:
  - register offset localparams (OFF_ID, OFF_CTRL, OFF_DATA, OFF_STATUS, OFF_ERR);
  - reset value constants;
  - CTRL_MASK = 32'h0000_00FF;
  - the state enum typedef bus_slv_state_e {IDLE, WAIT, GRANT}.
- One sub-module, bus_reg_file. It takes the decoded offset, write enable, read enable, the commit strobe and the captured wdata. It returns rdata and an error flag, and holds every register and acc_cnt.
- The top level keeps the FSM, the wait counter, the capture registers and the window check.

Test Plan:
- Reset then read 0x1000 (WAIT_CYCLES=0) -> gnt 2 cycles after req is sampled; rdata=32'hA5E4_0001; rdata is 0 in every other cycle.
- Write 0x1008=32'hDEAD_BEEF, then read 0x1008 back-to-back -> read returns DEAD_BEEF; STATUS reads 32'h0000_0002 afterwards (the STATUS read itself is the third access and counts after it completes).
- Write 0x1004=32'h1234_5678 -> read 0x1004 returns 32'h0000_0078; write 0x1000=0 -> ID unchanged and ERR[0]=0.
- Read 0x2000, then read 0x1014 -> both granted with rdata=0; ERR reads 1; write 0x1010=1 -> ERR reads 0.
- WAIT_CYCLES=3; addr changes during WAIT -> gnt 5 cycles after req is sampled; the captured addr is used; exactly one gnt per request.
- Assert rst_n=0 during WAIT of a write to DATA -> no gnt; DATA stays 0; next transfer behaves normally.
